ifetch: RTL and testbench
=========================

# ifetch

Parametrised instruction-fetch front end for the hart. It replaces the combinational imem port with a request/response memory interface and buffers fetched words in a DEPTH-entry prefetch queue. Each word is presented to decode with its PC. A redirect input handles taken branches, jumps and traps: it flushes the queue and discards responses that are still in flight. It sits between the PC/imem boundary and the decoder.

## Interface
- RESET_ADDR, 32'h00000000: first fetch address after reset.
- DEPTH, 4: prefetch queue entries; power of two, ≥2. This also bounds outstanding requests.

- i_clk  input  1  global clock
- i_rst_n  input  1  synchronous, active-low reset
- o_imem_req_valid  output  1  fetch request valid
- i_imem_req_ready  input  1  memory accepts request
- o_imem_req_addr  output  32  word-aligned fetch address
- i_imem_rsp_valid  input  1  response valid; in order, ≥1 cycle after acceptance, never back-pressured
- i_imem_rsp_data  input  32  instruction word
- o_inst_valid  output  1  queue head valid
- i_inst_ready  input  1  decode accepts head
- o_inst  output  32  instruction word at head
- o_inst_pc  output  32  PC of head
- o_inst_trap  output  1  head is a misaligned-fetch trap marker; o_inst is 0
- i_redirect  input  1  redirect request
- i_redirect_pc  input  32  redirect target

## Operation
**Reset** (i_rst_n=0 at a rising edge):
- fetch PC = RESET_ADDR
- queue empty
- outstanding = 0
- discard = 0
- state RUN
- all outputs 0

**Credit rule:**
- o_imem_req_valid = (state==RUN) && (outstanding + occupancy < DEPTH).
- The credit count is clog2(DEPTH)+1 bits wide and never exceeds DEPTH.

**Request handshake:**
- A request issues on a cycle with valid && ready.
- On issue, fetch PC += 4 (32-bit wrap) and outstanding++.
- o_imem_req_addr is stable while valid && !ready, except in a redirect cycle.

**Responses:**
- Each response decrements outstanding.
- If discard > 0, the response is dropped and discard--.
- Otherwise the word is written to the queue tail with its PC. The queue's PC register advances by 4 per enqueue.

**Dequeue:** happens on o_inst_valid && i_inst_ready.

**States:**
- RUN: normal fetch.
- HALT: no requests issued. Entered after a misaligned redirect. Exited only by a redirect or by reset.

**Redirect** (i_redirect=1):
- The queue is flushed.
- discard = outstanding remaining after this cycle. This includes a request accepted in the same cycle, and excludes a response arriving in the same cycle, which is itself dropped.
- If i_redirect_pc[1:0]==0: fetch PC = target, state RUN.
- Otherwise: one entry {o_inst_trap=1, o_inst_pc=target, o_inst=0} is enqueued and state becomes HALT.

**Simultaneous events:**
- A dequeue in the same cycle as a redirect counts as accepted before the flush.
- Simultaneous enqueue and dequeue when full is legal. Occupancy is unchanged.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

## Timing
- Reset to first request: o_imem_req_valid=1 with RESET_ADDR in the first cycle after i_rst_n rises.
- Response to o_inst_valid: 1 cycle, because queue outputs are registered.
- Redirect to request for the target: the next cycle.
- Redirect to o_inst_valid for the target: at least memory latency + 1 cycle after that request.
- Reset mid-operation: takes effect immediately. Outstanding responses arriving after reset are not tracked; the memory is reset alongside.
- Throughput: one instruction per cycle sustained when memory latency ≤ DEPTH−1.

## Configuration
- IFETCH_STATS_EN defined: adds three ports, each a 32-bit output that counts from 0 after reset and wraps:
  - o_stat_fetched: enqueued words
  - o_stat_discarded: dropped responses
  - o_stat_stall: cycles with o_inst_valid=0 while state==RUN
- IFETCH_STATS_EN undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- Reset release, memory latency 1, always ready, i_inst_ready=1 → requests at 0x0, 0x4, 0x8, …; first o_inst_valid 2 cycles after reset release; then one instruction per cycle with o_inst_pc = 0x0, 0x4, 0x8 in order.
- i_inst_ready=0, DEPTH=4 → exactly 4 requests issue, then o_imem_req_valid=0. Raising i_inst_ready drains 4 entries with correct PCs, and fetching resumes.
- 3 requests outstanding, latency 3, redirect to 0x100 → the next 3 responses are dropped (o_stat_discarded=3 with the macro); the next delivered o_inst_pc = 0x100.
- Redirect to 0x102 → a single entry with o_inst_trap=1, o_inst_pc=0x102; no further requests until a redirect to 0x200 restarts fetch at 0x200.
- i_imem_req_ready toggling every cycle → o_imem_req_addr holds while stalled; no PC is skipped or duplicated.
- Reset asserted while the queue holds 2 entries → o_inst_valid=0 the next cycle; fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/ifetch.sv
// ifetch: request/response instruction fetch with a DEPTH-entry prefetch queue and redirect flush.
// Define IFETCH_STATS_EN to add fetched/discarded/stall counters.
module ifetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_trap,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0] o_stat_fetched,
  output logic [31:0] o_stat_discarded,
  output logic [31:0] o_stat_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] CAP = (AW+2)'(DEPTH);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, enq_pc;
  logic [AW:0] outstanding, out_nx, discard, wr_ptr, rd_ptr, occ;
  logic [AW+1:0] load;
  logic [31:0] q_data [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic [DEPTH-1:0] q_trap;
  logic issue, deq, drop, enq, misal, we;
  assign misal = |i_redirect_pc[1:0];
  assign occ = wr_ptr - rd_ptr;
  assign load = {1'b0, outstanding} + {1'b0, occ};
  assign o_imem_req_valid = i_rst_n && state == RUN && load < CAP;
  assign o_imem_req_addr = fetch_pc;
  assign o_inst_valid = i_rst_n && wr_ptr != rd_ptr;
  assign o_inst = o_inst_valid ? q_data[rd_ptr[AW-1:0]] : 32'h0;
  assign o_inst_pc = o_inst_valid ? q_pc[rd_ptr[AW-1:0]] : 32'h0;
  assign o_inst_trap = o_inst_valid && q_trap[rd_ptr[AW-1:0]];
  assign issue = o_imem_req_valid && i_imem_req_ready;
  assign deq = o_inst_valid && i_inst_ready;
  // a response landing in a redirect cycle belongs to the abandoned path
  assign drop = i_imem_rsp_valid && (i_redirect || discard != '0);
  assign enq = i_imem_rsp_valid && !drop;
  assign out_nx = outstanding + {{AW{1'b0}}, issue} - {{AW{1'b0}}, i_imem_rsp_valid};
  assign we = i_redirect ? misal : enq;
  always_comb begin
    state_nx = state;
    if (i_redirect) state_nx = misal ? HALT : RUN;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= RUN;
    else state <= state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc <= RESET_ADDR;
      enq_pc <= RESET_ADDR;
      outstanding <= '0;
      discard <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      outstanding <= out_nx;
      if (i_redirect) begin
        discard <= out_nx;
        rd_ptr <= wr_ptr;
        wr_ptr <= misal ? wr_ptr + 1'b1 : wr_ptr;
        fetch_pc <= misal ? fetch_pc : i_redirect_pc;
        enq_pc <= misal ? enq_pc : i_redirect_pc;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (drop) discard <= discard - 1'b1;
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (enq) enq_pc <= enq_pc + 32'd4;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (we) begin
      q_data[wr_ptr[AW-1:0]] <= i_redirect ? 32'h0 : i_imem_rsp_data;
      q_pc[wr_ptr[AW-1:0]] <= i_redirect ? i_redirect_pc : enq_pc;
      q_trap[wr_ptr[AW-1:0]] <= i_redirect;
    end
  end
`ifdef IFETCH_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stat_fetched <= '0;
      o_stat_discarded <= '0;
      o_stat_stall <= '0;
    end else begin
      o_stat_fetched <= o_stat_fetched + {31'b0, enq};
      o_stat_discarded <= o_stat_discarded + {31'b0, drop};
      o_stat_stall <= o_stat_stall + {31'b0, state == RUN && !o_inst_valid};
    end
  end
`endif
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: random-latency memory model plus program-order scoreboard for ifetch.
module tb_ifetch;
  localparam logic [31:0] RA = 32'h0000_0000;
  localparam int DEPTH = 4;
  logic clk = 0;
  always #5 clk = ~clk;
  logic i_rst_n, i_imem_req_ready, i_imem_rsp_valid, i_inst_ready, i_redirect;
  logic [31:0] i_imem_rsp_data, i_redirect_pc;
  logic o_imem_req_valid, o_inst_valid, o_inst_trap;
  logic [31:0] o_imem_req_addr, o_inst, o_inst_pc;
`ifdef IFETCH_STATS_EN
  logic [31:0] stat_fetched, stat_discarded, stat_stall;
`endif
  ifetch #(.RESET_ADDR(RA), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
    .o_imem_req_addr(o_imem_req_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_inst_trap(o_inst_trap),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
`ifdef IFETCH_STATS_EN
    , .o_stat_fetched(stat_fetched), .o_stat_discarded(stat_discarded), .o_stat_stall(stat_stall)
`endif
  );
  typedef struct {logic [31:0] addr; int due;} txn_t;
  txn_t mq[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_due = 0;
  logic [31:0] exp_pc, req_exp, trap_pc, prev_addr, force_pc;
  bit trap_pending, exp_halted, req_halted, prev_stall, force_redir, ready_toggle;
  int lat_min = 1, lat_max = 1, p_ready = 100, p_iready = 100, p_redir = 0;
  int cnt_issue = 0, cnt_deq = 0, cnt_trap = 0, total_deq = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      i_rst_n = 0;
      i_imem_req_ready = 0;
      i_imem_rsp_valid = 0;
      i_imem_rsp_data = 0;
      i_inst_ready = 0;
      i_redirect = 0;
      i_redirect_pc = 0;
      #1;
      check("rst_req_valid", 32'(o_imem_req_valid), 0);
      check("rst_inst_valid", 32'(o_inst_valid), 0);
      check("rst_inst", o_inst, 0);
      check("rst_inst_pc", o_inst_pc, 0);
      check("rst_inst_trap", 32'(o_inst_trap), 0);
    end
    exp_pc = RA;
    req_exp = RA;
    trap_pending = 0;
    exp_halted = 0;
    req_halted = 0;
    prev_stall = 0;
    mq.delete();
    last_due = 0;
  endtask

  task automatic step();
    bit redir, iss, dq;
    logic [31:0] tgt;
    int due;
    @(negedge clk);
    cyc++;
    i_rst_n = 1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      i_imem_rsp_valid = 1;
      i_imem_rsp_data = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      i_imem_rsp_valid = 0;
      i_imem_rsp_data = $urandom;
    end
    i_imem_req_ready = ready_toggle ? cyc[0] : ($urandom_range(99) < p_ready);
    i_inst_ready = $urandom_range(99) < p_iready;
    redir = force_redir || (p_redir > 0 && $urandom_range(999) < (req_halted ? 100 : p_redir));
    tgt = $urandom & 32'h0000_3FFC;
    if ($urandom_range(3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
    if (force_redir) tgt = force_pc;
    force_redir = 0;
    i_redirect = redir;
    i_redirect_pc = redir ? tgt : $urandom;
    #1;
    if (prev_stall) begin
      check("req_hold_valid", 32'(o_imem_req_valid), 1);
      check("req_hold_addr", o_imem_req_addr, prev_addr);
    end
    if (req_halted) check("halt_req_valid", 32'(o_imem_req_valid), 0);
    if (exp_halted) check("halt_inst_valid", 32'(o_inst_valid), 0);
    iss = o_imem_req_valid && i_imem_req_ready;
    if (iss) begin
      cnt_issue++;
      if (!redir) begin
        check("req_addr", o_imem_req_addr, req_exp);
        req_exp += 4;
      end
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: o_imem_req_addr, due: due});
    end
    dq = o_inst_valid && i_inst_ready;
    if (dq && !exp_halted) begin
      cnt_deq++;
      total_deq++;
      if (trap_pending) begin
        check("trap_flag", 32'(o_inst_trap), 1);
        check("trap_pc", o_inst_pc, trap_pc);
        check("trap_inst", o_inst, 0);
        trap_pending = 0;
        exp_halted = 1;
        cnt_trap++;
      end else begin
        check("deq_trap", 32'(o_inst_trap), 0);
        check("deq_pc", o_inst_pc, exp_pc);
        check("deq_inst", o_inst, mem_word(exp_pc));
        exp_pc += 4;
      end
    end
    if (redir) begin
      if (tgt[1:0] == 2'b00) begin
        exp_pc = tgt;
        req_exp = tgt;
        trap_pending = 0;
        exp_halted = 0;
        req_halted = 0;
      end else begin
        trap_pending = 1;
        trap_pc = tgt;
        exp_halted = 0;
        req_halted = 1;
      end
    end
    prev_stall = o_imem_req_valid && !i_imem_req_ready && !redir;
    prev_addr = o_imem_req_addr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    i_rst_n = 0;
    i_imem_req_ready = 0;
    i_imem_rsp_valid = 0;
    i_imem_rsp_data = 0;
    i_inst_ready = 0;
    i_redirect = 0;
    i_redirect_pc = 0;
    do_reset(2);
    // streaming at latency 1
    step();
    check("first_req_valid", 32'(o_imem_req_valid), 1);
    check("first_req_addr", o_imem_req_addr, RA);
    t = 0;
    while (!o_inst_valid && t < 10) begin
      step();
      t++;
    end
    check("first_inst_latency", t, 2);
    for (int k = 0; k < 6; k++) begin
      step();
      check("throughput_valid", 32'(o_inst_valid), 1);
    end
    // credit limit with decode stalled
    do_reset(1);
    p_iready = 0;
    cnt_issue = 0;
    repeat (8) step();
    check("credit_issues", cnt_issue, DEPTH);
    check("credit_stop", 32'(o_imem_req_valid), 0);
    p_iready = 100;
    cnt_issue = 0;
    cnt_deq = 0;
    repeat (8) step();
    check("drain_count", 32'(cnt_deq >= DEPTH), 1);
    check("fetch_resumes", 32'(cnt_issue > 0), 1);
    // redirect with three requests in flight
    do_reset(1);
    lat_min = 3;
    lat_max = 3;
    cnt_issue = 0;
    cnt_deq = 0;
    step();
    step();
    force_redir = 1;
    force_pc = 32'h100;
    step();
    check("inflight_at_redirect", cnt_issue, 3);
    repeat (12) step();
    check("redirect_delivers", 32'(cnt_deq > 0), 1);
`ifdef IFETCH_STATS_EN
    check("stat_discarded", stat_discarded, 3);
`endif
    // misaligned redirect traps and halts, aligned redirect restarts
    lat_min = 1;
    lat_max = 2;
    cnt_trap = 0;
    force_redir = 1;
    force_pc = 32'h102;
    step();
    repeat (10) step();
    check("trap_seen", cnt_trap, 1);
    cnt_deq = 0;
    force_redir = 1;
    force_pc = 32'h200;
    step();
    repeat (10) step();
    check("restart_delivers", 32'(cnt_deq > 0), 1);
    // memory ready toggling every cycle
    ready_toggle = 1;
    lat_max = 3;
    repeat (40) step();
    ready_toggle = 0;
    // reset while queue is occupied
    do_reset(1);
    lat_max = 1;
    p_iready = 0;
    repeat (4) step();
    check("pre_reset_valid", 32'(o_inst_valid), 1);
    do_reset(1);
    p_iready = 100;
    step();
    check("post_reset_inst_valid", 32'(o_inst_valid), 0);
    check("post_reset_req_valid", 32'(o_imem_req_valid), 1);
    check("post_reset_req_addr", o_imem_req_addr, RA);
    // randomized episodes
    for (int e = 0; e < 30; e++) begin
      if ($urandom_range(3) == 0) do_reset(1);
      lat_min = 1;
      lat_max = $urandom_range(1, 5);
      p_ready = $urandom_range(30, 100);
      p_iready = $urandom_range(20, 100);
      p_redir = $urandom_range(0, 40);
      repeat (100) step();
    end
    check("random_progress", 32'(total_deq > 500), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
